// File: rtl/rgb565_frame_reader_pkg.sv
// Constants, FSM encoding and colour expansion used by the RGB565 frame-buffer stages.
package rgb565_frame_reader_pkg;

    localparam int IMG_WIDTH  = 480;
    localparam int IMG_HEIGHT = 272;
    localparam int MEM_DEPTH  = IMG_WIDTH * IMG_HEIGHT;
    localparam int ADDR_WIDTH = 17;
    localparam int DATA_WIDTH = 16;
    localparam int PIX_WIDTH  = 24;
    localparam int FIFO_WIDTH = PIX_WIDTH + 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Bit replication keeps full-scale codes full-scale (0x1F -> 0xFF).
    function automatic logic [PIX_WIDTH-1:0] rgb565_to_888(input logic [15:0] rgb);
        return {rgb[15:11], rgb[15:13], rgb[10:5], rgb[10:9], rgb[4:0], rgb[4:2]};
    endfunction

endpackage

// File: rtl/rgb565_frame_reader_pix_fifo2.sv
// Two-entry synchronous FIFO with clock enable; head is shown combinationally.
module pix_fifo2
    import rgb565_frame_reader_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [1:0]       count
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign do_push = push && (count_reg != 2'd2);
    assign do_pop  = pop && (count_reg != 2'd0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_reg;

        always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
                entry_reg <= '0;
            end else if (clk_en && do_push && (wr_ptr_reg == 1'(gi))) begin
                entry_reg <= wdata;
            end
        end
    end

    assign rdata = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
    assign empty = (count_reg == 2'd0);
    assign count = count_reg;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (clk_en) begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rgb565_frame_reader.sv
// Reads a completed RGB565 frame from RAM in raster order and streams it as RGB888
// with SOF/EOL/EOF markers over valid/ready.
module rgb565_frame_reader
    import rgb565_frame_reader_pkg::*;
#(
    parameter int IMG_WIDTH  = rgb565_frame_reader_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT = rgb565_frame_reader_pkg::IMG_HEIGHT,
    parameter int ADDR_WIDTH = rgb565_frame_reader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = rgb565_frame_reader_pkg::DATA_WIDTH
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic                  i_Clk_en,
    input  logic                  i_start,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic [23:0]           o_pix,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sof,
    output logic                  o_eol,
    output logic                  o_eof,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int X_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic [X_W-1:0]          x_reg;
    logic [Y_W-1:0]          y_reg;
    logic                    rvalid_reg;
    logic [2:0]              side_reg;
    logic                    busy_reg;
    logic                    done_reg;

    logic [FIFO_WIDTH-1:0]   fifo_wdata;
    logic [FIFO_WIDTH-1:0]   fifo_rdata;
    logic                    fifo_pop;
    logic                    fifo_empty;
    logic [1:0]              fifo_count;
    logic [2:0]              credit_used;
    logic                    issue;
    logic                    last_addr;
    logic                    sof_c;
    logic                    eol_c;
    logic                    eof_c;

    // A pop in this cycle frees its slot in time for a read issued now, which is
    // what lets two credits sustain one pixel per cycle across the RAM latency.
    assign fifo_pop    = ~fifo_empty & i_ready;
    assign credit_used = {2'b00, rvalid_reg} + {1'b0, fifo_count} - {2'b00, fifo_pop};
    assign issue       = (state_reg == ST_RUN) && (credit_used < 3'd2);

    assign last_addr = (rd_addr_reg == ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1));
    assign sof_c     = (x_reg == '0) && (y_reg == '0);
    assign eol_c     = (x_reg == X_W'(IMG_WIDTH - 1));
    assign eof_c     = eol_c && (y_reg == Y_W'(IMG_HEIGHT - 1));

    assign fifo_wdata = {rgb565_to_888(i_rd_data[15:0]), side_reg};

    pix_fifo2 #(
        .WIDTH (FIFO_WIDTH)
    ) u_pix_fifo2 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .clk_en (i_Clk_en),
        .push   (rvalid_reg),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_reg   <= ST_IDLE;
            rd_addr_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            rvalid_reg  <= 1'b0;
            side_reg    <= 3'b000;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else if (i_Clk_en) begin
            rvalid_reg <= issue;
            done_reg   <= 1'b0;
            if (issue) side_reg <= {sof_c, eol_c, eof_c};

            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        state_reg   <= ST_RUN;
                        rd_addr_reg <= '0;
                        x_reg       <= '0;
                        y_reg       <= '0;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        rd_addr_reg <= rd_addr_reg + 1'b1;
                        if (eol_c) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 1'b1;
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                        if (last_addr) state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_pop && fifo_rdata[0]) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rd_en   = issue;
    assign o_rd_addr = rd_addr_reg;
    assign o_pix     = fifo_rdata[FIFO_WIDTH-1:3];
    assign o_sof     = fifo_rdata[2];
    assign o_eol     = fifo_rdata[1];
    assign o_eof     = fifo_rdata[0];
    assign o_valid   = ~fifo_empty;
    assign o_busy    = busy_reg;
    assign o_done    = done_reg;

endmodule
